// File: rtl/byte_splitter.sv
// byte_splitter: captures a 32-bit word, presents it as four parallel byte
// lanes and streams the same four bytes over a valid/ready serial port.
module byte_splitter #(
  parameter bit SER_MSB_FIRST = 1'b1  // 1: O1..O4 order, 0: O4..O1 order
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  O1,
  output logic [7:0]  O2,
  output logic [7:0]  O3,
  output logic [7:0]  O4,
  output logic        out_valid,
  output logic [7:0]  ser_byte,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_last
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold;
  logic        accept;
  logic [1:0]  pos;
  logic [1:0]  sel;

  // A word is taken only when the serializer is idle.
  assign accept = in_valid && in_ready;

  assign O1 = hold[31:24];
  assign O2 = hold[23:16];
  assign O3 = hold[15:8];
  assign O4 = hold[7:0];

  // Holding register and the one-cycle update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        hold <= A;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and serial-port outputs, all decoded from state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    pos       = 2'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = B0;
        end
      end
      B0: begin
        ser_valid = 1'b1;
        pos       = 2'd0;
        if (ser_ready) begin
          state_nxt = B1;
        end
      end
      B1: begin
        ser_valid = 1'b1;
        pos       = 2'd1;
        if (ser_ready) begin
          state_nxt = B2;
        end
      end
      B2: begin
        ser_valid = 1'b1;
        pos       = 2'd2;
        if (ser_ready) begin
          state_nxt = B3;
        end
      end
      B3: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        pos       = 2'd3;
        if (ser_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte selection: stream position mapped to lane index (0 = O1) by order.
  always_comb begin
    sel      = SER_MSB_FIRST ? pos : (2'd3 - pos);
    ser_byte = '0;
    if (ser_valid) begin
      case (sel)
        2'd0:    ser_byte = hold[31:24];
        2'd1:    ser_byte = hold[23:16];
        2'd2:    ser_byte = hold[15:8];
        default: ser_byte = hold[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_byte_splitter.sv
// Bench for byte_splitter: both serial orders driven from shared stimulus and
// checked every cycle against a queue-based reference model.
module tb_byte_splitter;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic        in_valid;
  logic        ser_ready;

  logic        m_in_ready, m_out_valid, m_ser_valid, m_ser_last;
  logic [7:0]  m_o1, m_o2, m_o3, m_o4, m_ser_byte;
  logic        l_in_ready, l_out_valid, l_ser_valid, l_ser_last;
  logic [7:0]  l_o1, l_o2, l_o3, l_o4, l_ser_byte;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference model state
  logic [31:0] mdl_word;
  logic        mdl_ov;
  logic [7:0]  q_msb[$];
  logic [7:0]  q_lsb[$];

  byte_splitter #(.SER_MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .A(A), .in_valid(in_valid), .in_ready(m_in_ready),
    .O1(m_o1), .O2(m_o2), .O3(m_o3), .O4(m_o4), .out_valid(m_out_valid),
    .ser_byte(m_ser_byte), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_last(m_ser_last)
  );

  byte_splitter #(.SER_MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .A(A), .in_valid(in_valid), .in_ready(l_in_ready),
    .O1(l_o1), .O2(l_o2), .O3(l_o3), .O4(l_o4), .out_valid(l_out_valid),
    .ser_byte(l_ser_byte), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_last(l_ser_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_word = '0;
    mdl_ov   = 1'b0;
    q_msb.delete();
    q_lsb.delete();
  endtask

  // Compare both instances with what the model says is visible now.
  task automatic check_all();
    logic [7:0] eb_m, eb_l;
    logic       busy;
    busy = (q_msb.size() != 0);
    eb_m = busy ? q_msb[0] : 8'h00;
    eb_l = busy ? q_lsb[0] : 8'h00;
    check("in_ready",   {m_in_ready, l_in_ready},   {2{!busy}});
    check("out_valid",  {m_out_valid, l_out_valid}, {2{mdl_ov}});
    check("lanes_msb",  {m_o1, m_o2, m_o3, m_o4},   mdl_word);
    check("lanes_lsb",  {l_o1, l_o2, l_o3, l_o4},   mdl_word);
    check("ser_valid",  {m_ser_valid, l_ser_valid}, {2{busy}});
    check("ser_last",   {m_ser_last, l_ser_last},   {2{q_msb.size() == 1}});
    check("ser_byte_m", {24'h0, m_ser_byte},        {24'h0, eb_m});
    check("ser_byte_l", {24'h0, l_ser_byte},        {24'h0, eb_l});
  endtask

  // One clock: apply inputs, advance the model on the edge, check at negedge.
  task automatic step(input logic v, input logic [31:0] a, input logic r);
    in_valid  = v;
    A         = a;
    ser_ready = r;
    @(posedge clk);
    if (q_msb.size() == 0) begin
      mdl_ov = v;
      if (v) begin
        mdl_word = a;
        for (int i = 3; i >= 0; i--) q_msb.push_back(a[i*8 +: 8]);
        for (int i = 0; i < 4; i++)  q_lsb.push_back(a[i*8 +: 8]);
      end
    end else begin
      mdl_ov = 1'b0;
      if (r) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int unsigned toggle;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; ser_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // small word, free-running sink
    step(1'b1, 32'h000041C3, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // back-pressure pattern 1,0,0,1,...
    step(1'b1, 32'hDEADBEEF, 1'b1);
    toggle = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 32'h0, (toggle % 3) == 0);
      toggle++;
    end

    // in_valid held high with changing data during streaming
    step(1'b1, 32'h11223344, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 32'hA0B0C0D0 + i, (i % 2) == 0);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // reset in the middle of a stream (third byte showing)
    step(1'b1, 32'hCAFEF00D, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("pre_rst_last", {31'h0, m_ser_last}, 32'h0);
    check("pre_rst_byte", {24'h0, m_ser_byte}, 32'h000000F0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
